axis_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one AXI-Stream master port among NUM_S AXI-Stream requesters, each of which is an axis_m-style source (8-bit tdata, tlast-terminated bursts). It sits between the stream sources and the single downstream consumer. It locks the output to one requester from grant until that requester's tlast beat is accepted, then rotates priority.

---
 rtl/axis_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_axis_rr_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_S AXI-Stream requesters share one
// master port, locked from grant until the granted requester's tlast is accepted.
module axis_rr_arbiter #(
  parameter int NUM_S  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = $clog2(NUM_S)
) (
  input  logic                      m_axis_aclk,
  input  logic                      m_axis_aresetn,
  input  logic [NUM_S*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_S-1:0]          s_axis_tvalid,
  input  logic [NUM_S-1:0]          s_axis_tlast,
  output logic [NUM_S-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_S - 1);
  localparam logic [ID_W:0]   NUM_EXT = (ID_W + 1)'(NUM_S);

  state_t          state, state_next;
  logic [ID_W-1:0] grant, grant_next;
  logic [ID_W-1:0] ptr, ptr_next;

  logic            any_req;
  logic [ID_W-1:0] winner;

  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              last_accept;

  // Round-robin search starting at ptr; the explicit wrap keeps a
  // non-power-of-2 NUM_S from stepping onto a nonexistent requester.
  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    winner  = ptr;
    any_req = 1'b0;
    for (int i = 0; i < NUM_S; i++) begin
      sum = {1'b0, ptr} + (ID_W + 1)'(i);
      if (sum >= NUM_EXT) sum = sum - NUM_EXT;
      idx = sum[ID_W-1:0];
      if (!any_req && s_axis_tvalid[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  // Select the granted requester's lanes; gated by state further down.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_S; i++) begin
      if (grant == ID_W'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  assign last_accept = (state == ST_BUSY) && sel_valid && sel_last && m_axis_tready;

  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_next = winner;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (last_accept) begin
          state_next = ST_IDLE;
          ptr_next   = (grant == LAST_ID) ? '0 : grant + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
    end
  end

  // Zero-latency pass-through while busy; everything quiet in IDLE, which
  // also makes the outputs drop as soon as reset clears the state.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (state == ST_BUSY) begin
      m_axis_tdata  = sel_data;
      m_axis_tvalid = sel_valid;
      m_axis_tlast  = sel_last;
      for (int i = 0; i < NUM_S; i++) begin
        if (grant == ID_W'(i)) s_axis_tready[i] = m_axis_tready;
      end
    end
  end

  assign busy     = (state == ST_BUSY);
  assign grant_id = grant;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: reset, single packet, backpressure,
// priority wrap, reset mid-packet and four-way fairness.
module tb_axis_rr_arbiter;

  localparam int NUM_S  = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_S*DATA_W-1:0] s_tdata;
  logic [NUM_S-1:0]        s_tvalid;
  logic [NUM_S-1:0]        s_tlast;
  logic [NUM_S-1:0]        s_tready;
  logic [DATA_W-1:0]       m_tdata;
  logic                    m_tvalid;
  logic                    m_tlast;
  logic                    m_tready;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;

  int total = 0;
  int bad   = 0;

  axis_rr_arbiter #(.NUM_S(NUM_S), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tready  (m_tready),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, leaving time to drive and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [7:0] d, input logic v, input logic l);
    s_tdata[i*DATA_W +: DATA_W] = d;
    s_tvalid[i] = v;
    s_tlast[i]  = l;
  endtask

  // Busy-side view of one beat of requester g.
  task automatic check_beat(input string tag, input int g, input logic [7:0] d, input logic l);
    #1;
    check({tag, "_busy"},  busy, 1'b1);
    check({tag, "_gid"},   grant_id, g);
    check({tag, "_data"},  m_tdata, d);
    check({tag, "_valid"}, m_tvalid, 1'b1);
    check({tag, "_last"},  m_tlast, l);
    check({tag, "_ready"}, s_tready, 4'b0001 << g);
  endtask

  task automatic check_idle(input string tag);
    #1;
    check({tag, "_busy"},   busy, 1'b0);
    check({tag, "_ready"},  s_tready, 4'b0000);
    check({tag, "_mvalid"}, m_tvalid, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    m_tready = 1'b1;
    s_tdata  = 32'hDEAD_BEEF;
    s_tvalid = 4'hF;
    s_tlast  = 4'hF;

    // Reset held with every requester valid.
    repeat (3) tick();
    check("rst_mdata",  m_tdata, 8'h00);
    check("rst_mvalid", m_tvalid, 1'b0);
    check("rst_mlast",  m_tlast, 1'b0);
    check("rst_sready", s_tready, 4'h0);
    check("rst_busy",   busy, 1'b0);
    check("rst_gid",    grant_id, 2'd0);
    s_tvalid = 4'h0;
    s_tlast  = 4'h0;
    s_tdata  = '0;
    rst_n    = 1'b1;
    tick();

    // Single requester s1: AA, BB, CC(last).
    set_src(1, 8'hAA, 1'b1, 1'b0);
    check_idle("s1_pre");
    tick();
    check_beat("s1_b0", 1, 8'hAA, 1'b0);
    tick();
    set_src(1, 8'hBB, 1'b1, 1'b0);
    check_beat("s1_b1", 1, 8'hBB, 1'b0);
    tick();
    set_src(1, 8'hCC, 1'b1, 1'b1);
    check_beat("s1_b2", 1, 8'hCC, 1'b1);
    tick();
    set_src(1, 8'h00, 1'b0, 1'b0);
    check_idle("s1_post");
    check("s1_post_gid", grant_id, 2'd1);

    // s2 with a two-cycle stall on its second beat; ptr is now 2.
    set_src(2, 8'h21, 1'b1, 1'b0);
    set_src(0, 8'h01, 1'b1, 1'b0);
    check_idle("bp_pre");
    tick();
    set_src(0, 8'h00, 1'b0, 1'b0);
    check_beat("bp_b0", 2, 8'h21, 1'b0);
    tick();
    set_src(2, 8'h22, 1'b1, 1'b0);
    check_beat("bp_b1", 2, 8'h22, 1'b0);
    m_tready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("bp_stall_data",  m_tdata, 8'h22);
      check("bp_stall_valid", m_tvalid, 1'b1);
      check("bp_stall_ready", s_tready, 4'h0);
      check("bp_stall_busy",  busy, 1'b1);
      tick();
    end
    m_tready = 1'b1;
    check_beat("bp_b1r", 2, 8'h22, 1'b0);
    tick();
    set_src(2, 8'h23, 1'b1, 1'b0);
    check_beat("bp_b2", 2, 8'h23, 1'b0);
    tick();
    set_src(2, 8'h24, 1'b1, 1'b1);
    check_beat("bp_b3", 2, 8'h24, 1'b1);
    tick();
    set_src(2, 8'h00, 1'b0, 1'b0);
    check_idle("bp_post");

    // Single-beat packet from s3; ptr wraps to 0 afterwards.
    set_src(3, 8'h3C, 1'b1, 1'b1);
    tick();
    check_beat("s3_b0", 3, 8'h3C, 1'b1);
    tick();
    set_src(3, 8'h00, 1'b0, 1'b0);
    check_idle("s3_post");
    check("s3_post_gid", grant_id, 2'd3);

    // s0 and s2 together: ptr=0 picks s0, then ptr=1 picks s2.
    set_src(0, 8'h0A, 1'b1, 1'b1);
    set_src(2, 8'h2A, 1'b1, 1'b1);
    tick();
    check_beat("wrap_s0", 0, 8'h0A, 1'b1);
    tick();
    set_src(0, 8'h0B, 1'b1, 1'b1);
    check_idle("wrap_gap");
    tick();
    check_beat("wrap_s2", 2, 8'h2A, 1'b1);
    tick();
    set_src(0, 8'h00, 1'b0, 1'b0);
    set_src(2, 8'h00, 1'b0, 1'b0);
    check_idle("wrap_post");

    // Reset on the second beat of a four-beat s1 packet.
    set_src(1, 8'h31, 1'b1, 1'b0);
    tick();
    check_beat("rmp_b0", 1, 8'h31, 1'b0);
    tick();
    set_src(1, 8'h32, 1'b1, 1'b0);
    check_beat("rmp_b1", 1, 8'h32, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rmp_async_mvalid", m_tvalid, 1'b0);
    check("rmp_async_mdata",  m_tdata, 8'h00);
    check("rmp_async_sready", s_tready, 4'h0);
    check("rmp_async_busy",   busy, 1'b0);
    check("rmp_async_gid",    grant_id, 2'd0);
    set_src(1, 8'h00, 1'b0, 1'b0);
    set_src(3, 8'h3D, 1'b1, 1'b1);
    tick();
    rst_n = 1'b1;
    check_idle("rmp_release");
    tick();
    check_beat("rmp_s3", 3, 8'h3D, 1'b1);
    tick();
    set_src(3, 8'h00, 1'b0, 1'b0);
    check_idle("rmp_post");

    // Fairness: all four continuously offer 2-beat packets; ptr starts at 0.
    for (int i = 0; i < NUM_S; i++) set_src(i, 8'h40 + 8'(i * 16), 1'b1, 1'b0);
    check_idle("fair_pre");
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % NUM_S;
      tick();
      check_beat("fair_b0", g, 8'h40 + 8'(g * 16), 1'b0);
      tick();
      set_src(g, 8'h41 + 8'(g * 16), 1'b1, 1'b1);
      check_beat("fair_b1", g, 8'h41 + 8'(g * 16), 1'b1);
      tick();
      set_src(g, 8'h40 + 8'(g * 16), 1'b1, 1'b0);
      check_idle("fair_gap");
      check("fair_gap_gid", grant_id, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
